// File: rtl/context_switch_ctrl_if.sv
// Bundle between the context-switch sequencer and the control unit, register file and data RAM.
`default_nettype none

interface context_switch_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  switch_req;
  logic [7:0]            target_prog;
  logic [DATA_WIDTH-1:0] current_pc;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [4:0]            rf_addr;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] pc_out;
  logic                  pc_load;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [7:0]            current_prog;

  modport master (
    input  switch_req, target_prog, current_pc, rf_rdata, mem_rdata,
    output rf_addr, rf_we, rf_wdata, mem_addr, mem_we, mem_wdata,
           pc_out, pc_load, busy, done, error, current_prog
  );

  modport slave (
    output switch_req, target_prog, current_pc, rf_rdata, mem_rdata,
    input  rf_addr, rf_we, rf_wdata, mem_addr, mem_we, mem_wdata,
           pc_out, pc_load, busy, done, error, current_prog
  );
endinterface

`default_nettype wire

// File: rtl/context_switch_ctrl.sv
// Saves the running program's PC/registers into its RAM partition, then restores the target's.
`default_nettype none

module context_switch_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int PARTITION    = 1000,
  parameter int NUM_PROGRAMS = 3,
  parameter int RESET_PROG   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  context_switch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAVE   = 3'd1,
    LOAD   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [4:0] K_LAST = 5'(NUM_REGS - 1);

  state_t          state_q, state_d;
  logic [4:0]      k_q, k_d;
  logic [7:0]      target_q, target_d;
  logic [7:0]      prog_q, prog_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_idx_q, wb_idx_d;

  logic [ADDR_WIDTH-1:0] save_base, load_base;

  assign save_base = ADDR_WIDTH'(prog_q)   * ADDR_WIDTH'(PARTITION);
  assign load_base = ADDR_WIDTH'(target_q) * ADDR_WIDTH'(PARTITION);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      target_q   <= '0;
      prog_q     <= 8'(RESET_PROG);
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      target_q   <= target_d;
      prog_q     <= prog_d;
      done_q     <= done_d;
      error_q    <= error_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    target_d   = target_q;
    prog_d     = prog_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    wb_valid_d = 1'b0;
    wb_idx_d   = wb_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.switch_req) begin
          if (32'(bus.target_prog) >= NUM_PROGRAMS) begin
            error_d = 1'b1;
          end else if (bus.target_prog == prog_q) begin
            done_d = 1'b1;
          end else begin
            target_d = bus.target_prog;
            k_d      = '0;
            state_d  = SAVE;
          end
        end
      end
      SAVE: begin
        k_d = k_q + 5'd1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // RAM data arrives one cycle later, so remember which word is in flight.
        wb_valid_d = 1'b1;
        wb_idx_d   = k_q;
        k_d        = k_q + 5'd1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        prog_d  = target_q;
        state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rf_addr   = '0;
    bus.rf_we     = 1'b0;
    bus.rf_wdata  = {DATA_WIDTH{1'b0}};
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = {DATA_WIDTH{1'b0}};
    bus.pc_out    = {DATA_WIDTH{1'b0}};
    bus.pc_load   = 1'b0;
    if (state_q == SAVE) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = save_base + ADDR_WIDTH'(k_q);
      if (k_q == 5'd0) begin
        bus.mem_wdata = bus.current_pc;
      end else begin
        bus.rf_addr   = k_q;
        bus.mem_wdata = bus.rf_rdata;
      end
    end
    if (state_q == LOAD) begin
      bus.mem_addr = load_base + ADDR_WIDTH'(k_q);
    end
    if (wb_valid_q) begin
      if (wb_idx_q == 5'd0) begin
        bus.pc_out  = bus.mem_rdata;
        bus.pc_load = 1'b1;
      end else begin
        bus.rf_we    = 1'b1;
        bus.rf_addr  = wb_idx_q;
        bus.rf_wdata = bus.mem_rdata;
      end
    end
  end

  assign bus.busy         = (state_q == SAVE) || (state_q == LOAD) || (state_q == DRAIN);
  assign bus.done         = done_q || (state_q == FINISH);
  assign bus.error        = error_q;
  assign bus.current_prog = prog_q;

endmodule

`default_nettype wire

// File: tb/tb_context_switch_ctrl.sv
// Directed bench for context_switch_ctrl with RAM/register-file/PC models and a transaction scoreboard.
`default_nettype none

module tb_context_switch_ctrl;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  context_switch_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  context_switch_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(32),
    .PARTITION(1000), .NUM_PROGRAMS(3), .RESET_PROG(1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  logic [31:0] ram [0:4095];
  logic [31:0] rf  [0:31];
  logic [31:0] pc_reg;
  logic [31:0] mem_rdata_q;
  logic        tb_init;

  assign bus.rf_rdata   = rf[bus.rf_addr];
  assign bus.current_pc = pc_reg;
  assign bus.mem_rdata  = mem_rdata_q;

  always @(posedge clock) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 32'h0;
      ram[2000] <= 32'h80;
      for (int j = 1; j < 32; j++) ram[2000 + j] <= 32'hA0 + 32'(j);
      rf[0] <= 32'hDEAD0000;
      for (int j = 1; j < 32; j++) rf[j] <= 32'(j * 3);
      pc_reg      <= 32'h40;
      mem_rdata_q <= 32'h0;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
      mem_rdata_q <= ram[bus.mem_addr[11:0]];
      if (bus.rf_we) rf[bus.rf_addr] <= bus.rf_wdata;
      if (bus.pc_load) pc_reg <= bus.pc_out;
    end
  end

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   e0 = 0;
  int   pc_load_cyc = -1;
  logic mon_en;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_unexpected_kind", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = sbq.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_addr", addr, e.addr);
      check("sb_data", data, e.data);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && reset_n && !tb_init) begin
      if (bus.mem_we && bus.rf_we) check("we_exclusive", 32'h1, 32'h0);
      if (bus.mem_we) pop_cmp(0, bus.mem_addr, bus.mem_wdata);
      if (bus.rf_we) pop_cmp(1, 32'(bus.rf_addr), bus.rf_wdata);
      if (bus.pc_load) begin
        pop_cmp(2, 32'h0, bus.pc_out);
        pc_load_cyc = cyc - e0 + 1;
      end
    end
  end

  function automatic logic [31:0] regval(input int set, input int j);
    if (set == 1) return (j == 0) ? 32'h40 : 32'(j * 3);
    return (j == 0) ? 32'h80 : 32'hA0 + 32'(j);
  endfunction

  task automatic push_switch(input int src, input int tgt, input int sset, input int tset);
    for (int k = 0; k < 32; k++) sbq.push_back('{0, 32'(src * 1000 + k), regval(sset, k)});
    sbq.push_back('{2, 32'h0, regval(tset, 0)});
    for (int j = 1; j < 32; j++) sbq.push_back('{1, 32'(j), regval(tset, j)});
  endtask

  task automatic start_switch(input logic [7:0] tgt);
    @(negedge clock);
    bus.switch_req  = 1'b1;
    bus.target_prog = tgt;
    @(posedge clock);
    #1;
    bus.switch_req = 1'b0;
    e0 = cyc;
  endtask

  task automatic run_switch(input logic [7:0] tgt, output int busy_cnt, output int done_cyc);
    start_switch(tgt);
    busy_cnt = 0;
    done_cyc = -1;
    for (int n = 1; n <= 200 && done_cyc < 0; n++) begin
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cyc = n;
    end
  endtask

  int bc, dc, ndone;

  initial begin
    reset_n         = 1'b0;
    tb_init         = 1'b1;
    mon_en          = 1'b1;
    bus.switch_req  = 1'b0;
    bus.target_prog = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_current_prog", 32'(bus.current_prog), 32'h1);
    @(negedge clock);
    tb_init = 1'b0;
    reset_n = 1'b1;

    // basic save + restore 1 -> 2
    push_switch(1, 2, 1, 2);
    pc_load_cyc = -1;
    run_switch(8'd2, bc, dc);
    check("s12_busy_cycles", 32'(bc), 32'd65);
    check("s12_done_cycle", 32'(dc), 32'd66);
    check("s12_pc_load_cycle", 32'(pc_load_cyc), 32'd34);
    @(negedge clock);
    check("s12_done_pulse", 32'(bus.done), 32'h0);
    check("s12_sb_empty", 32'(sbq.size()), 32'h0);
    check("s12_current_prog", 32'(bus.current_prog), 32'h2);
    check("s12_pc", pc_reg, 32'h80);
    check("s12_reg0", rf[0], 32'hDEAD0000);
    check("s12_reg5", rf[5], 32'hA5);
    check("s12_reg31", rf[31], 32'hBF);
    check("s12_ram1000", ram[1000], 32'h40);
    check("s12_ram1031", ram[1031], 32'd93);

    // round trip 2 -> 1
    push_switch(2, 1, 2, 1);
    run_switch(8'd1, bc, dc);
    check("s21_done_cycle", 32'(dc), 32'd66);
    @(negedge clock);
    check("s21_sb_empty", 32'(sbq.size()), 32'h0);
    check("s21_current_prog", 32'(bus.current_prog), 32'h1);
    check("s21_pc", pc_reg, 32'h40);
    for (int j = 1; j < 32; j++) check("s21_reg", rf[j], 32'(j * 3));
    check("s21_reg0", rf[0], 32'hDEAD0000);

    // same target
    run_switch(8'd1, bc, dc);
    check("same_busy_cycles", 32'(bc), 32'd0);
    check("same_done_cycle", 32'(dc), 32'd1);
    repeat (3) @(negedge clock);
    check("same_sb_empty", 32'(sbq.size()), 32'h0);

    // invalid target
    start_switch(8'd3);
    @(negedge clock);
    check("inv_error", 32'(bus.error), 32'h1);
    check("inv_busy", 32'(bus.busy), 32'h0);
    check("inv_done", 32'(bus.done), 32'h0);
    @(negedge clock);
    check("inv_error_pulse", 32'(bus.error), 32'h0);
    check("inv_current_prog", 32'(bus.current_prog), 32'h1);

    // request while busy is ignored
    push_switch(1, 2, 1, 2);
    start_switch(8'd2);
    ndone = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      if (bus.done) ndone++;
      if (n == 20) begin
        bus.switch_req  = 1'b1;
        bus.target_prog = 8'd0;
      end else begin
        bus.switch_req = 1'b0;
      end
    end
    check("busyreq_done_count", 32'(ndone), 32'd1);
    check("busyreq_current_prog", 32'(bus.current_prog), 32'h2);
    check("busyreq_sb_empty", 32'(sbq.size()), 32'h0);

    // asynchronous reset in the middle of SAVE
    mon_en = 1'b0;
    start_switch(8'd0);
    repeat (10) @(negedge clock);
    check("abort_busy_before", 32'(bus.busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_mem_we", 32'(bus.mem_we), 32'h0);
    check("abort_mem_addr", bus.mem_addr, 32'h0);
    check("abort_mem_wdata", bus.mem_wdata, 32'h0);
    check("abort_rf_addr", 32'(bus.rf_addr), 32'h0);
    check("abort_rf_we", 32'(bus.rf_we), 32'h0);
    check("abort_pc_load", 32'(bus.pc_load), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_error", 32'(bus.error), 32'h0);
    check("abort_current_prog", 32'(bus.current_prog), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
